// File: rtl/valid_ready_fifo_level.sv
`default_nettype none
// ============================================================================
// Module   : valid_ready_fifo_level
// Brief    : Valid/ready circular FIFO of arbitrary depth with occupancy count,
//            almost-full/almost-empty flags, synchronous flush and drop counter.
// Revision : 1.0 - initial release
// ============================================================================
module valid_ready_fifo_level #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 10,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] down_data,
    output logic [CNT_W-1:0] count,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [15:0]      drop_cnt
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_ptr_last  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_full  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_af_level  = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] c_ae_level  = CNT_W'(AE_LEVEL);
    localparam logic [15:0]      c_drop_max  = 16'hFFFF;

    // Elaboration-time parameter legality checks
    if (DEPTH < 2 || DEPTH > 1024) begin : g_bad_depth
        $error("valid_ready_fifo_level: DEPTH must be in 2..1024");
    end
    if (AF_LEVEL > DEPTH || AF_LEVEL < 0) begin : g_bad_af
        $error("valid_ready_fifo_level: AF_LEVEL must be in 0..DEPTH");
    end
    if (AE_LEVEL >= DEPTH || AE_LEVEL < 0) begin : g_bad_ae
        $error("valid_ready_fifo_level: AE_LEVEL must be in 0..DEPTH-1");
    end
    if (CNT_W != $clog2(DEPTH + 1)) begin : g_bad_cnt_w
        $error("valid_ready_fifo_level: CNT_W is derived and must not be overridden");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [15:0]      r_drop_cnt;

    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;

    // Handshake depends only on registered count, never on the peer's strobe
    assign up_ready   = (r_count != c_cnt_full);
    assign down_valid = (r_count != '0);

    assign w_push = up_valid & up_ready;
    assign w_pop  = down_valid & down_ready;
    assign w_drop = up_valid & ~up_ready;

    assign w_wr_ptr_nxt = (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;

    assign down_data    = r_mem[r_rd_ptr];
    assign count        = r_count;
    assign almost_full  = (r_count >= c_af_level);
    assign almost_empty = (r_count <= c_ae_level);
    assign drop_cnt     = r_drop_cnt;

    // Storage is never reset; writes only on an accepted, non-flushed push
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_push) begin
            r_mem[r_wr_ptr] <= up_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Refused pushes are counted even during a flush cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && r_drop_cnt != c_drop_max) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_valid_ready_fifo_level.sv
`default_nettype none
// ============================================================================
// Module   : tb_valid_ready_fifo_level
// Brief    : Directed self-checking bench for valid_ready_fifo_level (depth 10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_valid_ready_fifo_level;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        up_valid;
    logic        up_ready;
    logic [7:0]  up_data;
    logic        down_valid;
    logic        down_ready;
    logic [7:0]  down_data;
    logic [3:0]  count;
    logic        almost_full;
    logic        almost_empty;
    logic [15:0] drop_cnt;

    int n_checks;
    int n_fail;

    valid_ready_fifo_level dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .up_valid     (up_valid),
        .up_ready     (up_ready),
        .up_data      (up_data),
        .down_valid   (down_valid),
        .down_ready   (down_ready),
        .down_data    (down_data),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        flush      = 1'b0;
        up_valid   = 1'b0;
        up_data    = 8'h00;
        down_ready = 1'b0;

        // Reset for two cycles
        tick();
        tick();
        rst = 1'b0;
        check("rst_count", count, 0);
        check("rst_down_valid", down_valid, 0);
        check("rst_up_ready", up_ready, 1);
        check("rst_almost_empty", almost_empty, 1);
        check("rst_almost_full", almost_full, 0);
        check("rst_drop_cnt", drop_cnt, 0);

        // Fill with 0x01..0x0A
        up_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            up_data = 8'(i);
            tick();
            check("fill_count", count, i);
            check("fill_almost_full", almost_full, (i >= 8) ? 1 : 0);
            check("fill_almost_empty", almost_empty, (i <= 2) ? 1 : 0);
        end
        check("full_up_ready", up_ready, 0);
        check("full_down_data", down_data, 8'h01);

        // Three refused pushes while full
        up_data = 8'hEE;
        tick();
        tick();
        tick();
        up_valid = 1'b0;
        check("drop_after_3", drop_cnt, 3);
        check("full_count_kept", count, 10);

        // Drain in order
        down_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            check("drain_valid", down_valid, 1);
            check("drain_data", down_data, i);
            tick();
            check("drain_count", count, 10 - i);
            check("drain_almost_empty", almost_empty, ((10 - i) <= 2) ? 1 : 0);
        end
        down_ready = 1'b0;
        check("drained_down_valid", down_valid, 0);

        // Advance pointers to 7, then push/pop 7 words across the 9 -> 0 wrap
        up_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            up_data = 8'(8'h20 + i);
            tick();
        end
        up_valid   = 1'b0;
        down_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check("pre_wrap_data", down_data, 8'h20 + i);
            tick();
        end
        down_ready = 1'b0;
        up_valid   = 1'b1;
        for (int i = 0; i < 7; i++) begin
            up_data = 8'(8'h30 + i);
            tick();
        end
        up_valid = 1'b0;
        check("wrap_count", count, 7);
        down_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check("wrap_data", down_data, 8'h30 + i);
            tick();
        end
        down_ready = 1'b0;
        check("wrap_empty", down_valid, 0);

        // Steady state push+pop at count 5
        up_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            up_data = 8'(8'h40 + i);
            tick();
        end
        down_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            up_data = 8'(8'h45 + k);
            check("steady_data", down_data, 8'h40 + k);
            tick();
            check("steady_count", count, 5);
        end
        down_ready = 1'b0;

        // Top up to full: contents 0x54..0x5D
        for (int i = 0; i < 5; i++) begin
            up_data = 8'(8'h59 + i);
            tick();
        end
        check("refull_count", count, 10);
        check("refull_up_ready", up_ready, 0);

        // Push+pop at full: first only the pop, then both
        up_data    = 8'h5E;
        down_ready = 1'b1;
        check("full_pp_head", down_data, 8'h54);
        tick();
        check("full_pp_count1", count, 9);
        check("full_pp_drop", drop_cnt, 4);
        check("full_pp_head1", down_data, 8'h55);
        tick();
        check("full_pp_count2", count, 9);
        check("full_pp_head2", down_data, 8'h56);
        up_valid = 1'b0;

        // Pop three to reach count 6
        tick();
        tick();
        tick();
        down_ready = 1'b0;
        check("pre_flush_count", count, 6);
        check("pre_flush_head", down_data, 8'h59);

        // Flush with push and pop asserted
        flush      = 1'b1;
        up_valid   = 1'b1;
        up_data    = 8'h77;
        down_ready = 1'b1;
        tick();
        flush      = 1'b0;
        down_ready = 1'b0;
        check("flush_count", count, 0);
        check("flush_down_valid", down_valid, 0);
        check("flush_drop_kept", drop_cnt, 4);

        up_data = 8'hAB;
        tick();
        up_valid = 1'b0;
        check("post_flush_valid", down_valid, 1);
        check("post_flush_data", down_data, 8'hAB);
        check("post_flush_count", count, 1);

        // Reset mid-stream
        up_valid = 1'b1;
        up_data  = 8'hCD;
        tick();
        check("mid_count", count, 2);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        up_valid = 1'b0;
        check("mid_rst_count", count, 0);
        check("mid_rst_drop", drop_cnt, 0);
        check("mid_rst_down_valid", down_valid, 0);
        check("mid_rst_up_ready", up_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
